tt_um_sequence_detector: RTL and testbench
==========================================

Name: tt_um_sequence_detector

Overview:
TinyTapeout user tile that detects the serial bit pattern 1011, with overlap allowed, on a sampled input stream. It keeps a 4-bit count of detections and shows that count as a hex digit on a 7-segment display. A one-cycle-resolution detect flag is also driven out. The block is the top level of the tile; power pins VPWR/VGND exist only in gate-level builds (GL_TEST).

Parameters:
none (pattern fixed at 1011, first bit received first)

Ports:
clk      input   1  system clock; all state on rising edge
rst_n    input   1  reset; asynchronous, active-high (1 = reset); name kept per tile convention
ena      input   1  tile enable; when 0, all state holds
ui_in    input   8  [0] serial data bit; [1] sample strobe; [2] synchronous count clear; [7:3] unused
uo_out   output  8  [6:0] 7-seg segments a..g, active-high; [7] detect flag
uio_in   input   8  unused
uio_out  output  8  [3:0] detection count; [7:4] = 0
uio_oe   output  8  constant 8'h0F

Behaviour:
- Reset (rst_n=1, async): state=S0, count=0. uo_out=8'h3F (digit 0, detect 0), uio_out=8'h00. Outputs take these values immediately, not waiting for a clock edge.
- The sample condition is ena & ui_in[1]. Without it, the FSM and count hold.
- Moore FSM. Transitions listed as "input 0 / input 1", taken on sampled edges only:
  - S0 (idle): S0 / S1
  - S1 ("1"): S2 / S1
  - S2 ("10"): S0 / S3
  - S3 ("101"): S2 / S4
  - S4 ("1011"): S2 / S1
- Detect: uo_out[7] = (state==S4). It rises the cycle after the edge that samples the final 1. It stays high while the FSM holds in S4 with no samples.
- Count increments (mod 16, 15 wraps to 0) on the same edge the FSM moves into S4. Holding in S4 does not recount.
- Clear: ena & ui_in[2] sets count=0 on the next edge and does not affect the FSM. If clear and a detect land on the same edge, clear wins (count=0). FSM still goes to S4.
- Display is combinational from count, segments {g,f,e,d,c,b,a} = uo_out[6:0]:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Display latency: it updates in the same cycle the detect flag rises.
- ena=0: strobe and clear are ignored; outputs still reflect held state.
- Reset asserted mid-sequence: partial match is discarded (S0), count cleared, detect drops at once.
- Unused inputs (ui_in[7:3], uio_in) have no effect.

Test Plan:
1. Assert rst_n=1, then release → uo_out=8'h3F, uio_out=8'h00, uio_oe=8'h0F.
2. Strobe bits 1,0,1,1 (ena=1) → uo_out[7]=1 the cycle after the 4th edge, uio_out=1, uo_out[6:0]=7'h06; next sampled 0 → detect 0, count stays 1.
3. Overlap: bits 1,0,1,1,0,1,1 → two detect pulses (after bits 4 and 7), count=2, segments 7'h5B. Bits 1,1,0,1,0,1,1 → one detect, count=1.
4. Strobe low for 5 cycles while in S4 → detect stays 1, count unchanged. ena=0 with strobe high → no state change.
5. Feed 16 detections → count walks 1..F (F shows 7'h71), then wraps to 0 (7'h3F). Clear asserted with count=5 → count=0 next edge; clear coincident with detect → count=0, detect=1.
6. Bits 1,0,1 then rst_n=1 between edges → outputs immediately 8'h3F. After release, bit 1 alone gives no detect; full 1011 is needed.

Source files
------------

// File: rtl/tt_um_sequence_detector.sv
// Purpose : TinyTapeout tile detecting serial pattern 1011 (overlapping) on a
//           strobed bit stream; counts hits mod 16 and shows the count in hex.
// Latency : detect flag and display update one cycle after the sampling edge;
//           no backpressure, a sample is taken on every edge with ena & strobe.
// Ports   : clk, rst_n (async, active-high reset), ena (global hold when 0)
//           ui_in[0] data bit, ui_in[1] sample strobe, ui_in[2] count clear
//           uo_out[6:0] segments {g,f,e,d,c,b,a}, uo_out[7] detect flag
//           uio_out[3:0] detection count, uio_oe fixed to 8'h0F
module tt_um_sequence_detector (
`ifdef GL_TEST
  inout  wire        VPWR,
  inout  wire        VGND,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Each state names the longest suffix of the stream that is a prefix of 1011.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_detect;
  logic [3:0] r_count;

  logic       w_bit;
  logic       w_sample;
  logic       w_clear;
  logic       w_enter_s4;
  logic [6:0] w_seg;
  logic       w_unused_ok;

  assign w_bit      = ui_in[0];
  assign w_sample   = ena & ui_in[1];
  assign w_clear    = ena & ui_in[2];
  // S4 is only reachable from S3 on a 1, so this marks exactly one count per hit.
  assign w_enter_s4 = w_sample & (r_state == S3) & w_bit;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= S0;
      r_detect <= 1'b0;
    end else if (w_sample) begin
      case (r_state)
        S0:      r_state <= w_bit ? S1 : S0;
        S1:      r_state <= w_bit ? S1 : S2;
        S2:      r_state <= w_bit ? S3 : S0;
        S3:      r_state <= w_bit ? S4 : S2;
        S4:      r_state <= w_bit ? S1 : S2;
        default: r_state <= S0;
      endcase
      // Registered copy of (next state == S4); holds while no samples arrive.
      r_detect <= w_enter_s4;
    end
  end

  // Clear takes priority over a coincident detection.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count <= 4'd0;
    end else if (w_clear) begin
      r_count <= 4'd0;
    end else if (w_enter_s4) begin
      r_count <= r_count + 4'd1;
    end
  end

  always_comb begin
    w_seg = 7'h3F;
    case (r_count)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h3F;
    endcase
  end

  assign uo_out  = {r_detect, w_seg};
  assign uio_out = {4'h0, r_count};
  assign uio_oe  = 8'h0F;

  // Unused tile inputs are deliberately ignored.
  assign w_unused_ok = &{1'b0, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_tt_um_sequence_detector.sv
module tb_tt_um_sequence_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tt_um_sequence_detector dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // Reference model: a hit is "the last four sampled bits read 1011".
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_hist;
  int         m_n;
  logic       m_det;
  logic [3:0] m_cnt;

  function automatic logic [7:0] exp_uo();
    return {m_det, seg_tbl[m_cnt]};
  endfunction

  task automatic model_reset();
    m_hist = 4'b0000;
    m_n    = 0;
    m_det  = 1'b0;
    m_cnt  = 4'd0;
  endtask

  // One clock: drive at negedge, model the rising edge, settle 1 time unit after.
  task automatic cyc(input logic en, input logic st, input logic b, input logic cl);
    @(negedge clk);
    ena    = en;
    ui_in  = {5'($urandom), cl, st, b};
    uio_in = 8'($urandom);
    @(posedge clk);
    if (en && st) begin
      m_hist = {m_hist[2:0], b};
      m_n    = m_n + 1;
      m_det  = (m_n >= 4) && (m_hist == 4'b1011);
    end
    if (en && cl) m_cnt = 4'd0;
    else if (en && st && m_det) m_cnt = m_cnt + 4'd1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    ui_in = 8'h00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (uo_out !== 8'h3F) $display("FAIL reset_uo got %h want 3f", uo_out);
    else n_pass++;
    n_checks++;
    if (uio_out !== 8'h00) $display("FAIL reset_uio got %h want 00", uio_out);
    else n_pass++;
    n_checks++;
    if (uio_oe !== 8'h0F) $display("FAIL reset_oe got %h want 0f", uio_oe);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (uo_out !== 8'h3F || uio_out !== 8'h00)
      $display("FAIL post_release got %h/%h want 3f/00", uo_out, uio_out);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [3:0] pat = 4'b1011;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b1, 1'b1, pat[i], 1'b0);
      n_checks++;
      if (uo_out !== exp_uo() || uio_out !== {4'h0, m_cnt})
        $display("FAIL single_bit%0d got %h/%h want %h/%h", 3 - i, uo_out, uio_out, exp_uo(), {4'h0, m_cnt});
      else n_pass++;
    end
    n_checks++;
    if (uo_out !== 8'h86 || uio_out !== 8'h01)
      $display("FAIL single_hit got %h/%h want 86/01", uo_out, uio_out);
    else n_pass++;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (uo_out !== 8'h06 || uio_out !== 8'h01)
      $display("FAIL single_drop got %h/%h want 06/01", uo_out, uio_out);
    else n_pass++;
  endtask

  task automatic test_overlap();
    logic [6:0] pa = 7'b1011011;
    logic [6:0] pb = 7'b1101011;
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, 1'b1, pa[i], 1'b0);
      if (uo_out[7]) pulses++;
      n_checks++;
      if (uo_out !== exp_uo()) $display("FAIL overlap_a_step got %h want %h", uo_out, exp_uo());
      else n_pass++;
    end
    n_checks++;
    if (pulses != 2 || uio_out !== 8'h02 || uo_out[6:0] !== 7'h5B)
      $display("FAIL overlap_a got pulses=%0d cnt=%h seg=%h want 2/02/5b", pulses, uio_out, uo_out[6:0]);
    else n_pass++;
    do_reset();
    pulses = 0;
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, 1'b1, pb[i], 1'b0);
      if (uo_out[7]) pulses++;
    end
    n_checks++;
    if (pulses != 1 || uio_out !== 8'h01)
      $display("FAIL overlap_b got pulses=%0d cnt=%h want 1/01", pulses, uio_out);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [3:0] pat = 4'b1011;
    do_reset();
    for (int i = 3; i >= 0; i--) cyc(1'b1, 1'b1, pat[i], 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, 1'($urandom), 1'b0);
      n_checks++;
      if (uo_out !== 8'h86 || uio_out !== 8'h01)
        $display("FAIL hold_s4 cyc%0d got %h/%h want 86/01", k, uo_out, uio_out);
      else n_pass++;
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 1'($urandom), 1'b1);
      n_checks++;
      if (uo_out !== 8'h86 || uio_out !== 8'h01)
        $display("FAIL hold_ena0 cyc%0d got %h/%h want 86/01", k, uo_out, uio_out);
      else n_pass++;
    end
    // State must have survived: 011 completes another hit from S4 via "1".
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (uo_out !== 8'hDB || uio_out !== 8'h02)
      $display("FAIL hold_resume got %h/%h want db/02", uo_out, uio_out);
    else n_pass++;
  endtask

  task automatic test_wrap_clear();
    logic [3:0] pat = 4'b1011;
    do_reset();
    for (int d = 1; d <= 16; d++) begin
      for (int i = 3; i >= 0; i--) cyc(1'b1, 1'b1, pat[i], 1'b0);
      n_checks++;
      if (uo_out !== exp_uo() || uio_out !== {4'h0, 4'(d)})
        $display("FAIL wrap_hit%0d got %h/%h want %h/%h", d, uo_out, uio_out, exp_uo(), {4'h0, 4'(d)});
      else n_pass++;
      if (d == 15) begin
        n_checks++;
        if (uo_out[6:0] !== 7'h71) $display("FAIL wrap_F got %h want 71", uo_out[6:0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (uo_out !== 8'hBF || uio_out !== 8'h00)
      $display("FAIL wrap_zero got %h/%h want bf/00", uo_out, uio_out);
    else n_pass++;
    for (int d = 0; d < 5; d++)
      for (int i = 3; i >= 0; i--) cyc(1'b1, 1'b1, pat[i], 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (uio_out !== 8'h00 || uo_out !== 8'hBF)
      $display("FAIL clear5 got %h/%h want bf/00", uo_out, uio_out);
    else n_pass++;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (uo_out !== 8'hBF || uio_out !== 8'h00)
      $display("FAIL clear_vs_hit got %h/%h want bf/00", uo_out, uio_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (uo_out !== 8'h3F || uio_out !== 8'h00)
      $display("FAIL async_reset got %h/%h want 3f/00", uo_out, uio_out);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (uo_out !== 8'h3F) $display("FAIL partial_discard got %h want 3f", uo_out);
    else n_pass++;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (uo_out !== 8'h86 || uio_out !== 8'h01)
      $display("FAIL after_reset_hit got %h/%h want 86/01", uo_out, uio_out);
    else n_pass++;
  endtask

  task automatic test_random();
    logic en, st, b, cl;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 3) != 0);
      b  = ($urandom_range(0, 2) != 0);
      cl = ($urandom_range(0, 29) == 0);
      cyc(en, st, b, cl);
      n_checks++;
      if (uo_out !== exp_uo() || uio_out !== {4'h0, m_cnt} || uio_oe !== 8'h0F)
        $display("FAIL random_cyc%0d got %h/%h/%h want %h/%h/0f", k, uo_out, uio_out, uio_oe,
                 exp_uo(), {4'h0, m_cnt});
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_overlap();
    test_hold();
    test_wrap_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
